// File: rtl/lsu_pkg.sv
// Shared constants, FSM encoding and access-size helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_WB    = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      WB    = ST_WB,
      ERR   = ST_ERR
   } lsu_state_e;

   // funct3[1:0] encodes log2 of the access size for both loads and stores
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         2'b10:   return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         2'b10:   return |off[1:0];
         default: return |off;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data path: moves the addressed bytes down to bit 0 and sign/zero extends by funct3.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [2:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data
);

   logic [XLEN-1:0] d;

   assign d = mem_rdata >> {off, 3'b000};

   always_comb begin
      load_data = d;
      case (funct3)
         F3_B:    load_data = {{(XLEN-8){d[7]}},   d[7:0]};
         F3_H:    load_data = {{(XLEN-16){d[15]}}, d[15:0]};
         F3_W:    load_data = {{(XLEN-32){d[31]}}, d[31:0]};
         F3_BU:   load_data = {{(XLEN-8){1'b0}},   d[7:0]};
         F3_HU:   load_data = {{(XLEN-16){1'b0}},  d[15:0]};
         F3_WU:   load_data = {{(XLEN-32){1'b0}},  d[31:0]};
         default: load_data = d;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one outstanding load/store on a valid/ready data port, with
// aligned/extended load write-back into the register file.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   store_data,
   input  logic [4:0]        rd_in,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic [4:0]        rd,
   output logic              RegWrite,
   output logic [XLEN-1:0]   write_data,
   output logic              misalign_err
);

   lsu_state_e      state_reg, state_next;
   logic            is_load_reg;
   logic [2:0]      funct3_reg;
   logic [XLEN-1:0] addr_reg;
   logic [XLEN-1:0] store_data_reg;
   logic [4:0]      rd_in_reg;
   logic [XLEN-1:0] load_data_reg;
   logic [XLEN-1:0] aligned_data;
   logic            accept;
   logic            illegal;
   logic            issue_store;

   assign accept = req_valid && (state_reg == IDLE);

   always_comb begin
      illegal = (is_load == is_store)
             || (is_load && (funct3 == 3'b111))
             || (is_store && funct3[2])
             || misaligned(funct3[1:0], addr[2:0]);
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid) state_next = illegal ? ERR : ISSUE;
         ISSUE:   if (mem_req_ready) state_next = is_load_reg ? WAIT : IDLE;
         WAIT:    if (mem_rsp_valid) state_next = WB;
         WB:      state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         is_load_reg    <= 1'b0;
         funct3_reg     <= 3'b000;
         addr_reg       <= '0;
         store_data_reg <= '0;
         rd_in_reg      <= 5'd0;
         load_data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            is_load_reg    <= is_load;
            funct3_reg     <= funct3;
            addr_reg       <= addr;
            store_data_reg <= store_data;
            rd_in_reg      <= rd_in;
         end
         // Capture the already-extended value so WB is a pure register output
         if ((state_reg == WAIT) && mem_rsp_valid) begin
            load_data_reg <= aligned_data;
         end
      end
   end

   lsu_load_align #(
      .XLEN(XLEN)
   ) u_load_align (
      .mem_rdata(mem_rdata),
      .off      (addr_reg[2:0]),
      .funct3   (funct3_reg),
      .load_data(aligned_data)
   );

   assign issue_store   = (state_reg == ISSUE) && !is_load_reg;

   assign req_ready     = (state_reg == IDLE);
   assign mem_req_valid = (state_reg == ISSUE);
   assign mem_we        = issue_store;
   assign mem_addr      = (state_reg == ISSUE) ? {addr_reg[XLEN-1:3], 3'b000} : '0;
   assign mem_wdata     = issue_store ? (store_data_reg << {addr_reg[2:0], 3'b000}) : '0;
   assign mem_wstrb     = issue_store ? (size_mask(funct3_reg[1:0]) << addr_reg[2:0]) : '0;

   assign rd            = (state_reg == WB) ? rd_in_reg : 5'd0;
   assign RegWrite      = (state_reg == WB) && (rd_in_reg != 5'd0);
   assign write_data    = (state_reg == WB) ? load_data_reg : '0;
   assign misalign_err  = (state_reg == ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, stalls, illegal requests and mid-access reset.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] store_data;
   logic [4:0]  rd_in;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;
   logic [4:0]  rd;
   logic        RegWrite;
   logic [63:0] write_data;
   logic        misalign_err;

   int checks   = 0;
   int failures = 0;

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .is_load      (is_load),
      .is_store     (is_store),
      .funct3       (funct3),
      .addr         (addr),
      .store_data   (store_data),
      .rd_in        (rd_in),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata    (mem_rdata),
      .rd           (rd),
      .RegWrite     (RegWrite),
      .write_data   (write_data),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Presents one request in IDLE and returns at the negedge after the accept edge
   task automatic issue_req(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] a, input logic [63:0] sd, input logic [4:0] r);
      @(negedge clk);
      req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
      addr = a; store_data = sd; rd_in = r;
      step();
      req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
      addr = '0; store_data = '0; rd_in = '0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b expected=1", req_ready); end
      checks++; if ({mem_req_valid, mem_we, RegWrite, misalign_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b expected=0000", {mem_req_valid, mem_we, RegWrite, misalign_err}); end
      checks++; if ({mem_addr, mem_wdata, mem_wstrb, rd, write_data} !== '0) begin failures++; $display("FAIL reset_buses got=%h expected=0", {mem_addr, mem_wdata, mem_wstrb, rd, write_data}); end
      rst_n = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_lb();
      issue_req(1'b1, 1'b0, F3_B, 64'h1003, 64'h0, 5'd5);
      checks++; if (mem_req_valid !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL lb_issue got=%b%b expected=10", mem_req_valid, req_ready); end
      checks++; if (mem_addr !== 64'h1000 || mem_we !== 1'b0 || mem_wstrb !== 8'h00) begin failures++; $display("FAIL lb_mem_fields got=%h/%b/%h expected=1000/0/00", mem_addr, mem_we, mem_wstrb); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL lb_wait_valid got=%b expected=0", mem_req_valid); end
      mem_rsp_valid = 1'b1; mem_rdata = 64'h00000000_80FF0000;
      step();
      mem_rsp_valid = 1'b0;
      checks++; if (RegWrite !== 1'b1 || rd !== 5'd5) begin failures++; $display("FAIL lb_wb got=%b/%0d expected=1/5", RegWrite, rd); end
      checks++; if (write_data !== 64'hFFFFFFFF_FFFFFF80) begin failures++; $display("FAIL lb_data got=%h expected=ffffffffffffff80", write_data); end
      step();
      checks++; if (RegWrite !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL lb_done got=%b/%b expected=0/1", RegWrite, req_ready); end
      $display("txn LB addr=1003 rd=5 data=%h", 64'hFFFFFFFF_FFFFFF80);
   endtask

   task automatic test_lwu_latency();
      issue_req(1'b1, 1'b0, F3_WU, 64'h2004, 64'h0, 5'd7);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (RegWrite !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL lwu_wait%0d got=%b/%b expected=0/0", i, RegWrite, req_ready); end
         step();
      end
      mem_rsp_valid = 1'b1; mem_rdata = 64'h87654321_00000000;
      step();
      mem_rsp_valid = 1'b0; mem_rdata = 64'hDEADBEEF_DEADBEEF;
      checks++; if (RegWrite !== 1'b1 || rd !== 5'd7) begin failures++; $display("FAIL lwu_wb got=%b/%0d expected=1/7", RegWrite, rd); end
      checks++; if (write_data !== 64'h00000000_87654321) begin failures++; $display("FAIL lwu_data got=%h expected=0000000087654321", write_data); end
      step();
      checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL lwu_one_cycle got=%b expected=0", RegWrite); end
      $display("txn LWU addr=2004 rd=7 data=%h", 64'h00000000_87654321);
   endtask

   task automatic test_extend();
      logic [2:0]  f3_tab  [6] = '{F3_H, F3_HU, F3_W, F3_BU, F3_D, F3_W};
      logic [2:0]  off_tab [6] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd0, 3'd4};
      logic [63:0] exp_tab [6] = '{64'hFFFFFFFF_FFFFB5A6, 64'h00000000_0000F1E2,
                                   64'hFFFFFFFF_B5A69788, 64'h00000000_00000097,
                                   64'hF1E2D3C4_B5A69788, 64'hFFFFFFFF_F1E2D3C4};
      for (int i = 0; i < 6; i++) begin
         issue_req(1'b1, 1'b0, f3_tab[i], {61'h20, off_tab[i]}, 64'h0, 5'd12);
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hF1E2D3C4_B5A69788;
         step();
         mem_rsp_valid = 1'b0;
         checks++; if (RegWrite !== 1'b1 || write_data !== exp_tab[i]) begin failures++; $display("FAIL extend%0d got=%b/%h expected=1/%h", i, RegWrite, write_data, exp_tab[i]); end
         step();
         $display("txn LOAD f3=%0d off=%0d data=%h", f3_tab[i], off_tab[i], exp_tab[i]);
      end
   endtask

   task automatic test_store_stall();
      issue_req(1'b0, 1'b1, F3_H, 64'h3006, 64'hBEEF, 5'd3);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_req_ready = 1'b1;
         checks++; if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h3000) begin failures++; $display("FAIL sh_hold%0d got=%b/%b/%h expected=1/1/3000", i, mem_req_valid, mem_we, mem_addr); end
         checks++; if (mem_wstrb !== 8'hC0 || mem_wdata !== 64'hBEEF0000_00000000) begin failures++; $display("FAIL sh_lane%0d got=%h/%h expected=c0/beef000000000000", i, mem_wstrb, mem_wdata); end
         checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL sh_regwrite%0d got=%b expected=0", i, RegWrite); end
         step();
      end
      mem_req_ready = 1'b0;
      checks++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || RegWrite !== 1'b0) begin failures++; $display("FAIL sh_done got=%b/%b/%b expected=1/0/0", req_ready, mem_req_valid, RegWrite); end
      $display("txn SH addr=3006 wstrb=c0 stalled=3");
   endtask

   task automatic test_back_to_back();
      issue_req(1'b0, 1'b1, F3_B, 64'h0005, 64'hAA, 5'd0);
      checks++; if (mem_wstrb !== 8'h20 || mem_wdata !== 64'h0000AA00_00000000) begin failures++; $display("FAIL sb_lane got=%h/%h expected=20/0000aa0000000000", mem_wstrb, mem_wdata); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL sb_latency got=%b expected=1", req_ready); end
      issue_req(1'b0, 1'b1, F3_D, 64'h0008, 64'h01234567_89ABCDEF, 5'd0);
      checks++; if (mem_wstrb !== 8'hFF || mem_wdata !== 64'h01234567_89ABCDEF || mem_addr !== 64'h8) begin failures++; $display("FAIL sd_lane got=%h/%h/%h expected=ff/0123456789abcdef/8", mem_wstrb, mem_wdata, mem_addr); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      $display("txn SB addr=5 then SD addr=8");
   endtask

   task automatic test_illegal();
      logic        ld_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        st_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3_tab [6] = '{F3_D, F3_W, F3_W, 3'b111, 3'b100, F3_H};
      logic [63:0] a_tab  [6] = '{64'h4004, 64'h0, 64'h0, 64'h0, 64'h0, 64'h1001};
      for (int i = 0; i < 6; i++) begin
         issue_req(ld_tab[i], st_tab[i], f3_tab[i], a_tab[i], 64'hFF, 5'd3);
         checks++; if (misalign_err !== 1'b1 || mem_req_valid !== 1'b0 || RegWrite !== 1'b0) begin failures++; $display("FAIL illegal%0d_err got=%b/%b/%b expected=1/0/0", i, misalign_err, mem_req_valid, RegWrite); end
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         checks++; if (misalign_err !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL illegal%0d_after got=%b/%b/%b expected=0/1/0", i, misalign_err, req_ready, mem_req_valid); end
         $display("txn ILLEGAL case=%0d addr=%h", i, a_tab[i]);
      end
   endtask

   task automatic test_rd_zero();
      issue_req(1'b1, 1'b0, F3_D, 64'h0, 64'h0, 5'd0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
      step();
      mem_rsp_valid = 1'b0;
      checks++; if (RegWrite !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rd0_wb got=%b/%b expected=0/0", RegWrite, req_ready); end
      step();
      checks++; if (RegWrite !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rd0_idle got=%b/%b expected=0/1", RegWrite, req_ready); end
      $display("txn LD rd=0 no write");
   endtask

   task automatic test_reset_mid();
      issue_req(1'b1, 1'b0, F3_B, 64'h10, 64'h0, 5'd9);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || RegWrite !== 1'b0 || misalign_err !== 1'b0) begin failures++; $display("FAIL rst_mid got=%b/%b/%b/%b expected=1/0/0/0", req_ready, mem_req_valid, RegWrite, misalign_err); end
      @(negedge clk);
      rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'hFF;
      step();
      mem_rsp_valid = 1'b0;
      checks++; if (RegWrite !== 1'b0 || req_ready !== 1'b1 || write_data !== 64'h0) begin failures++; $display("FAIL rst_late_rsp got=%b/%b/%h expected=0/1/0", RegWrite, req_ready, write_data); end
      step();
      checks++; if (RegWrite !== 1'b0 || rd !== 5'd0) begin failures++; $display("FAIL rst_after got=%b/%0d expected=0/0", RegWrite, rd); end
      $display("txn RESET during WAIT");
   endtask

   initial begin
      test_reset();
      test_lb();
      test_lwu_latency();
      test_extend();
      test_store_stall();
      test_back_to_back();
      test_illegal();
      test_rd_zero();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
